postadder: RTL and testbench

POSTADDER -- requirements
Module: postadder

---
 rtl/fp_pkg.sv | 27 ++
 rtl/rounder.sv | 61 ++++++
 rtl/postadder.sv | 176 +++++++++++++++++
 tb/tb_postadder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point post-adder.
// Holds the default field widths, IEEE-754 single constants, bit positions inside
// the 27-bit raw-sum mantissa, and the post-adder FSM state type.
`timescale 1ns/1ps
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  // Raw-sum layout: carry | hidden | fraction | guard | round
  localparam int unsigned MANT_W     = FRAC_W + 4;
  localparam int unsigned CARRY_BIT  = FRAC_W + 3;
  localparam int unsigned HIDDEN_BIT = FRAC_W + 2;
  localparam int unsigned LSB_BIT    = 2;
  localparam int unsigned GUARD_BIT  = 1;
  localparam int unsigned ROUND_BIT  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } state_t;

endpackage

// File: rtl/rounder.sv
// Combinational round-to-nearest-even and result packing for the post-adder.
// Ports:
//   sign      - result sign
//   exp       - biased exponent after normalisation (two guard bits above EXP_W)
//   mantis    - normalised mantissa: carry(clear), hidden, fraction, guard, round
//   sticky    - OR of all bits lost below the round bit
//   result    - packed IEEE-754 single
//   overflow  - result saturated to infinity
//   underflow - result is subnormal or zero
`timescale 1ns/1ps
module rounder #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic              sign,
  input  logic [EXP_W+1:0]  exp,
  input  logic [FRAC_W+3:0] mantis,
  input  logic              sticky,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);
  import fp_pkg::*;

  localparam int unsigned ExpIW = EXP_W + 2;
  localparam int unsigned SigW  = FRAC_W + 1;
  localparam logic [ExpIW-1:0] ExpSat = ExpIW'((1 << EXP_W) - 1);

  logic              inc;
  logic [SigW:0]     sig_rnd;
  logic [ExpIW-1:0]  exp_rnd;
  logic [FRAC_W-1:0] frac;
  logic              hidden;

  always_comb begin
    inc     = mantis[GUARD_BIT] & (mantis[ROUND_BIT] | sticky | mantis[LSB_BIT]);
    // Carry bit of mantis is clear here, so the top bit of sig_rnd is the rounding carry.
    sig_rnd = mantis[FRAC_W+3:2] + {{SigW{1'b0}}, inc};
    exp_rnd = exp;
    frac    = sig_rnd[FRAC_W-1:0];
    hidden  = sig_rnd[FRAC_W];
    if (sig_rnd[SigW]) begin
      exp_rnd = exp + ExpIW'(1);
      frac    = sig_rnd[FRAC_W:1];
      hidden  = 1'b1;
    end

    overflow  = 1'b0;
    underflow = 1'b0;
    if (exp_rnd >= ExpSat) begin
      overflow = 1'b1;
      result   = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (!hidden) begin
      underflow = 1'b1;
      result    = {sign, {EXP_W{1'b0}}, frac};
    end else begin
      result = {sign, exp_rnd[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/postadder.sv
// Floating-point adder post-processing: normalises a raw significand sum, rounds it to
// nearest-even and packs an IEEE-754 single with overflow/underflow flags.
// Build option: POSTADDER_LZC_EN - when defined, left normalisation completes in one
// cycle using a leading-zero count; otherwise it shifts one bit per cycle.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   in_valid/in_ready           - operand handshake (ready only when idle)
//   in_sign, in_exp, in_mantis  - raw sum sign, biased exponent, carry|hidden|frac|G|R
//   in_loss                     - sticky bit from the alignment shift
//   out_valid/out_ready         - result handshake
//   out_result                  - packed single; out_overflow/out_underflow flags
`timescale 1ns/1ps
module postadder #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+3:0] in_mantis,
  input  logic              in_loss,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow
);
  import fp_pkg::*;

  localparam int unsigned MantW     = FRAC_W + 4;
  localparam int unsigned CarryBit  = FRAC_W + 3;
  localparam int unsigned HiddenBit = FRAC_W + 2;
  localparam int unsigned ExpIW     = EXP_W + 2;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [ExpIW-1:0]   exp_q, exp_d;
  logic [MantW-1:0]   mant_q, mant_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [31:0]        rnd_result;
  logic               rnd_ovf;
  logic               rnd_unf;

`ifdef POSTADDER_LZC_EN
  logic [ExpIW-1:0]   lzc;
  logic [ExpIW-1:0]   shift_amt;
  logic               found;

  // Leading zeros from the hidden position down, clamped so the exponent stops at 1.
  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = HiddenBit; i >= 0; i--) begin
      if (!found) begin
        if (mant_q[i]) found = 1'b1;
        else           lzc   = lzc + ExpIW'(1);
      end
    end
    shift_amt = (lzc < exp_q - ExpIW'(1)) ? lzc : exp_q - ExpIW'(1);
  end
`endif

  rounder #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_rounder (
    .sign      (sign_q),
    .exp       (exp_q),
    .mantis    (mant_q),
    .sticky    (sticky_q),
    .result    (rnd_result),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = {2'b00, in_exp};
          mant_d   = in_mantis;
          sticky_d = in_loss;
          if (in_mantis == '0) begin
            result_d = {in_sign, 31'b0};
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            state_d  = StDone;
          end else begin
            state_d = StNorm;
          end
        end
      end

      StNorm: begin
        if (mant_q[CarryBit]) begin
          mant_d   = mant_q >> 1;
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + ExpIW'(1);
          state_d  = StRound;
        end else if (!mant_q[HiddenBit] && (exp_q > ExpIW'(1))) begin
`ifdef POSTADDER_LZC_EN
          mant_d  = mant_q << shift_amt;
          exp_d   = exp_q - shift_amt;
          state_d = StRound;
`else
          mant_d = mant_q << 1;
          exp_d  = exp_q - ExpIW'(1);
          // Leave once this shift lands the hidden bit or reaches the minimum exponent.
          if (mant_q[HiddenBit-1] || (exp_q == ExpIW'(2))) state_d = StRound;
`endif
        end else begin
          state_d = StRound;
        end
      end

      StRound: begin
        result_d = rnd_result;
        ovf_d    = rnd_ovf;
        unf_d    = rnd_unf;
        state_d  = StDone;
      end

      StDone: begin
        if (out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StDone);
  assign out_result    = result_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_postadder.sv
// Self-checking bench for postadder: directed vectors plus randomized operands compared
// against an arithmetic reference model. Latency is counted with the accept edge as edge 1.
`timescale 1ns/1ps
module tb_postadder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mantis;
  logic        in_loss;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  postadder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mantis     (in_mantis),
    .in_loss       (in_loss),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Value model: significand m has 1.0 at bit 25; G/R are bits 1/0; s is sticky.
  function automatic void ref_model(input bit sgn, input int e_in, input longint m_in,
                                    input bit s_in, output logic [31:0] res,
                                    output bit ovf, output bit unf, output int n);
    longint m;
    longint q;
    int     e;
    int     msb;
    int     sh;
    int     rem;
    bit     s;
    bit     up;
    m = m_in; e = e_in; s = s_in;
    ovf = 1'b0; unf = 1'b0; n = 1;
    if (m == 0) begin
      res = {sgn, 31'b0};
      n   = 0;
      return;
    end
    msb = 0;
    for (int i = 0; i < 27; i++) if (m[i]) msb = i;
    if (msb == 26) begin
      s = s | m[0];
      m = m >> 1;
      e = e + 1;
    end else if (msb < 25) begin
      sh = 25 - msb;
      if (sh > e - 1) sh = e - 1;
      if (sh < 0) sh = 0;
      m = m << sh;
      e = e - sh;
`ifndef POSTADDER_LZC_EN
      if (sh > 1) n = sh;
`endif
    end
    q   = m >> 2;
    rem = int'(m & 3);
    // Discarded part compared with half an ulp (rem==2 with no sticky is exactly half).
    if (rem == 3 || (rem == 2 && s)) up = 1'b1;
    else if (rem == 2)               up = q[0];
    else                             up = 1'b0;
    q = q + longint'(up);
    if (q >= (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      ovf = 1'b1;
      res = {sgn, 8'hFF, 23'b0};
    end else if (q < (64'd1 << 23)) begin
      unf = 1'b1;
      res = {sgn, 8'h00, q[22:0]};
    end else begin
      res = {sgn, e[7:0], q[22:0]};
    end
  endfunction

  task automatic run_op(input bit sgn, input logic [7:0] e, input logic [26:0] m,
                        input bit loss, input int stall, output logic [31:0] got);
    logic [31:0] res;
    bit          ovf;
    bit          unf;
    int          n;
    int          edges;
    ref_model(sgn, int'(e), longint'(m), loss, res, ovf, unf, n);
    @(negedge clk);
    check_eq("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_sign   = sgn;
    in_exp    = e;
    in_mantis = m;
    in_loss   = loss;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges    = 1;
    while (!out_valid && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    check_eq("out_valid_seen", {31'b0, out_valid}, 32'd1);
    if (n > 0) check_eq("latency", edges, n + 2);
    check_eq("result", out_result, res);
    check_eq("overflow", {31'b0, out_overflow}, {31'b0, ovf});
    check_eq("underflow", {31'b0, out_underflow}, {31'b0, unf});
    got = out_result;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check_eq("stall_result", out_result, res);
      check_eq("stall_hs", {30'b0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("release_hs", {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  typedef struct {
    bit          s;
    logic [7:0]  e;
    logic [26:0] m;
    bit          l;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] got;
    logic [26:0] m;
    logic [26:0] r;
    logic [7:0]  e;
    int          cls;
    int          msb;

    vecs[0] = '{s: 1'b0, e: 8'd127, m: 27'h4000000, l: 1'b0, r: 32'h40000000};
    vecs[1] = '{s: 1'b0, e: 8'd127, m: 27'h0000008, l: 1'b0, r: 32'h34800000};
    vecs[2] = '{s: 1'b0, e: 8'd127, m: 27'h2000002, l: 1'b0, r: 32'h3F800000};
    vecs[3] = '{s: 1'b0, e: 8'd127, m: 27'h2000006, l: 1'b0, r: 32'h3F800002};
    vecs[4] = '{s: 1'b0, e: 8'd127, m: 27'h2000002, l: 1'b1, r: 32'h3F800001};
    vecs[5] = '{s: 1'b0, e: 8'd254, m: 27'h7FFFFFF, l: 1'b0, r: 32'h7F800000};
    vecs[6] = '{s: 1'b1, e: 8'd127, m: 27'h0000000, l: 1'b0, r: 32'h80000000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mantis = '0;
    in_loss   = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_result", out_result, 32'd0);
    check_eq("rst_flags", {30'b0, out_overflow, out_underflow}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].l, (i == 0) ? 5 : 0, got);
      check_eq($sformatf("vec%0d", i), got, vecs[i].r);
    end

    // Reset while normalising aborts the operation.
    @(negedge clk);
    in_valid  = 1'b1;
    in_sign   = 1'b0;
    in_exp    = 8'd127;
    in_mantis = 27'h0000008;
    in_loss   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("abort_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_hs", {30'b0, out_valid, in_ready}, 32'd1);
    repeat (30) begin
      @(posedge clk); #1;
    end
    check_eq("abort_stays_idle", {30'b0, out_valid, in_ready}, 32'd1);

    for (int t = 0; t < 300; t++) begin
      cls = $urandom_range(0, 5);
      r   = 27'($urandom);
      case (cls)
        0: begin m = {1'b1, r[25:0]}; e = 8'($urandom_range(1, 253)); end
        1: begin m = {2'b01, r[24:0]}; e = 8'($urandom_range(1, 254)); end
        2: begin
          msb = $urandom_range(0, 24);
          m   = (27'(1) << msb) | (r & ((27'(1) << msb) - 27'(1)));
          e   = 8'($urandom_range(1, 254));
        end
        3: begin
          msb = $urandom_range(0, 25);
          m   = (27'(1) << msb) | (r & ((27'(1) << msb) - 27'(1)));
          e   = 8'($urandom_range(1, 24));
        end
        4: begin m = r; e = 8'($urandom_range(250, 255)); end
        default: begin m = '0; e = 8'($urandom); end
      endcase
      run_op(1'($urandom), e, m, 1'($urandom), $urandom_range(0, 3), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
